// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/forwarding control for a 5-stage pipeline
module pipeline_hazard_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic             mem_access,
   input  logic             mem_ready,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);
   localparam int WW = $clog2(MEM_TIMEOUT) + 1;
   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
   state_t state;
   logic [WW-1:0] wait_cnt;
   logic mem_stall, frozen, load_use, fa_mem, fa_wb, fb_mem, fb_wb;
   // enables, flushes and forwarding selects; reset, memory stall and halt freeze everything
   always_comb begin
      mem_stall = mem_access & ~mem_ready & (state != HALT);
      frozen = rst | mem_stall | (state == HALT);
      load_use = ex_mem_read & (ex_rd != 5'd0) &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
      pc_en = ~frozen & (ex_branch_taken | ~load_use);
      if_id_en = pc_en;
      id_ex_en = ~frozen;
      ex_mem_en = ~frozen;
      mem_wb_en = ~frozen;
      if_id_flush = rst | (~frozen & ex_branch_taken);
      id_ex_flush = rst | (~frozen & (ex_branch_taken | load_use));
      fa_mem = mem_reg_write & (mem_rd != 5'd0) & (mem_rd == ex_rs1);
      fa_wb = wb_reg_write & (wb_rd != 5'd0) & (wb_rd == ex_rs1);
      fb_mem = mem_reg_write & (mem_rd != 5'd0) & (mem_rd == ex_rs2);
      fb_wb = wb_reg_write & (wb_rd != 5'd0) & (wb_rd == ex_rs2);
      fwd_a_sel = rst ? 2'b00 : fa_mem ? 2'b01 : fa_wb ? 2'b10 : 2'b00;
      fwd_b_sel = rst ? 2'b00 : fb_mem ? 2'b01 : fb_wb ? 2'b10 : 2'b00;
   end
   // memory-wait tracking; a completed access returns to RUN, an overlong wait halts until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         wait_cnt <= '0;
         halted <= 1'b0;
      end else if (state != HALT) begin
         if (!mem_stall) begin
            state <= RUN;
            wait_cnt <= '0;
         end else if (state == MEM_WAIT && wait_cnt == WW'(MEM_TIMEOUT)) begin
            state <= HALT;
            halted <= 1'b1;
         end else begin
            state <= MEM_WAIT;
            wait_cnt <= wait_cnt + WW'(1);
         end
      end
   end
   // saturating count of cycles in which the PC did not advance
   always_ff @(posedge clk) begin
      if (rst) stall_cycles <= '0;
      else if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
   end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors checked by a queue-based scoreboard
module tb_pipeline_hazard_controller;
   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
   logic mem_reg_write, mem_access, mem_ready, wb_reg_write;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halted;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic [2:0] stall_cycles;
   typedef struct {
      string nm;
      logic [4:0] en;
      logic [1:0] fl;
      logic [1:0] fa;
      logic [1:0] fb;
      logic h;
      logic [2:0] sc;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int fails = 0;

   pipeline_hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .mem_access(mem_access), .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, string fld, int act, int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
      end
   endfunction

   // monitor: outputs are sampled mid-cycle against the oldest pending expectation
   always @(negedge clk) begin
      if (q.size() != 0) begin
         automatic exp_t e = q.pop_front();
         chk(e.nm, "en", int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), int'(e.en));
         chk(e.nm, "flush", int'({if_id_flush, id_ex_flush}), int'(e.fl));
         chk(e.nm, "fwd_a", int'(fwd_a_sel), int'(e.fa));
         chk(e.nm, "fwd_b", int'(fwd_b_sel), int'(e.fb));
         chk(e.nm, "halted", int'(halted), int'(e.h));
         chk(e.nm, "stall_cycles", int'(stall_cycles), int'(e.sc));
      end
   end

   task automatic idle();
      {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
      {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken} = '0;
      {mem_reg_write, mem_access, wb_reg_write} = '0;
      mem_ready = 1'b1;
   endtask

   task automatic cyc(string nm, logic [4:0] en, logic [1:0] fl, logic [1:0] fa, logic [1:0] fb,
                      logic h, logic [2:0] sc);
      exp_t e;
      e.nm = nm; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.h = h; e.sc = sc;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic lw5();
      ex_mem_read = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5;
   endtask

   initial begin
      rst = 1;
      idle();
      @(posedge clk);
      #1;
      ex_rs1 = 7; mem_rd = 7; mem_reg_write = 1;
      cyc("reset", 5'b00000, 2'b11, 2'b00, 2'b00, 0, 0);
      rst = 0; idle();
      cyc("idle", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 0);
      lw5();
      cyc("load_use", 5'b00111, 2'b01, 2'b00, 2'b00, 0, 0);
      idle();
      cyc("after_bubble", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 1);
      ex_mem_read = 1; ex_rd = 0; id_uses_rs2 = 1; id_rs2 = 0;
      cyc("lu_x0", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 1);
      idle(); ex_mem_read = 1; ex_rd = 3; id_rs2 = 3;
      cyc("lu_unused", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 1);
      idle(); lw5(); ex_branch_taken = 1;
      cyc("branch_lu", 5'b11111, 2'b11, 2'b00, 2'b00, 0, 1);
      idle();
      cyc("after_branch", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 1);
      mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 7; ex_rs2 = 7;
      cyc("fwd_mem", 5'b11111, 2'b00, 2'b01, 2'b01, 0, 1);
      mem_reg_write = 0;
      cyc("fwd_wb", 5'b11111, 2'b00, 2'b10, 2'b10, 0, 1);
      mem_rd = 0; mem_reg_write = 1; wb_rd = 9; ex_rs1 = 9; ex_rs2 = 0;
      cyc("fwd_x0", 5'b11111, 2'b00, 2'b10, 2'b00, 0, 1);
      mem_rd = 4; wb_rd = 4; wb_reg_write = 0; ex_rs1 = 4; ex_rs2 = 5;
      cyc("fwd_mix", 5'b11111, 2'b00, 2'b01, 2'b00, 0, 1);
      idle(); mem_access = 1; mem_ready = 0;
      cyc("mwait1", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 1);
      ex_branch_taken = 1; lw5();
      cyc("mwait2_br", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 2);
      idle(); mem_access = 1; mem_ready = 0; mem_rd = 7; mem_reg_write = 1; ex_rs1 = 7;
      cyc("mwait3_fwd", 5'b00000, 2'b00, 2'b01, 2'b00, 0, 3);
      idle(); mem_access = 1;
      cyc("mwait_done", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 4);
      idle();
      cyc("back_run", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 4);
      mem_access = 1;
      cyc("single_acc", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 4);
      mem_ready = 0;
      cyc("mid_stall", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 4);
      rst = 1;
      cyc("mid_reset", 5'b00000, 2'b11, 2'b00, 2'b00, 0, 5);
      rst = 0;
      cyc("to_1", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc("to_2", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 1);
      cyc("to_3", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 2);
      cyc("to_4", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 3);
      cyc("to_5", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 4);
      cyc("halt", 5'b00000, 2'b00, 2'b00, 2'b00, 1, 5);
      idle(); ex_branch_taken = 1;
      cyc("halt_br", 5'b00000, 2'b00, 2'b00, 2'b00, 1, 6);
      idle();
      cyc("halt_7", 5'b00000, 2'b00, 2'b00, 2'b00, 1, 7);
      cyc("halt_sat", 5'b00000, 2'b00, 2'b00, 2'b00, 1, 7);
      ex_rs2 = 4; wb_rd = 4; wb_reg_write = 1;
      cyc("halt_fwd", 5'b00000, 2'b00, 2'b00, 2'b10, 1, 7);
      idle(); rst = 1;
      cyc("halt_reset", 5'b00000, 2'b11, 2'b00, 2'b00, 1, 7);
      rst = 0;
      cyc("post_reset", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 0);
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush/forwarding controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Drives per-register enables and flushes, and forwarding selects for the EX operands.
- Sequences load-use stalls, taken-branch flushes and data-memory wait states.
- Halts the core on a memory timeout.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before halt (≥2)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_rs1, id_rs2  in  5 each  source regs of instruction in ID
id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
ex_rs1, ex_rs2  in  5 each  source regs of instruction in EX
ex_rd  in  5  dest reg in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved branch/jump taken
mem_rd  in  5  dest reg in MEM
mem_reg_write  in  1  MEM instruction writes rd
mem_access  in  1  MEM instruction is load/store
mem_ready  in  1  data memory completes access this cycle
wb_rd  in  5  dest reg in WB
wb_reg_write  in  1  WB instruction writes rd
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register advance enables
if_id_flush, id_ex_flush  out  1 each  load bubble (NOP, control zeroed) instead of data
fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 regfile, 01 MEM alu_res, 10 WB wb_data
halted  out  1  sticky memory-timeout halt
stall_cycles  out  CNT_W  cycles with pc_en=0 since reset (saturating)

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. wait_cnt is internal, $clog2(MEM_TIMEOUT)+1 bits.
- rst=1 (takes effect at the next edge; outputs during rst are combinational):
  - All *_en=0; if_id_flush=id_ex_flush=1; fwd_*=00.
  - Next state RUN; wait_cnt=0, stall_cycles=0, halted=0.
  - Reset mid-MEM_WAIT or in HALT returns to RUN.
- Memory stall: mem_access & !mem_ready, in RUN or MEM_WAIT.
  - All five enables=0, no flushes (full freeze). Overrides branch and load-use.
  - RUN→MEM_WAIT; wait_cnt=1 on entry, +1 per MEM_WAIT cycle.
  - mem_ready=1 → that cycle behaves as RUN (normal rules); next state RUN, wait_cnt=0. A single-cycle access (ready on first cycle) never leaves RUN.
  - In MEM_WAIT with wait_cnt==MEM_TIMEOUT and !mem_ready → HALT.
- HALT: all enables=0, flushes=0, halted=1 until rst.
- Branch flush (RUN, no mem stall, ex_branch_taken=1):
  - pc_en=1 (PC loads target); if_id_flush=1, id_ex_flush=1; other enables=1.
  - Takes priority over load-use.
- Load-use (RUN, no mem stall, no branch): ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - pc_en=0, if_id_en=0, id_ex_flush=1; id_ex/ex_mem/mem_wb enables=1.
  - Exactly one bubble per hazard.
- Otherwise: all enables=1, flushes=0.
- Forwarding (combinational, all states):
  - Operand A: fwd_a_sel=01 if mem_reg_write & mem_rd≠0 & mem_rd==ex_rs1; else 10 if wb_reg_write & wb_rd≠0 & wb_rd==ex_rs1; else 00.
  - Operand B: same rules with ex_rs2.
  - MEM beats WB. x0 never forwarded.
- stall_cycles: +1 on each non-reset cycle with pc_en=0 (includes HALT); saturates at all-ones.

Test Plan:
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5), ID uses rs1=5 → 1 cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables=1; stall_cycles=1.
- Taken branch with concurrent load-use condition → pc_en=1, if_id_flush=id_ex_flush=1, no stall; stall_cycles unchanged.
- Forward: mem_rd=wb_rd=7, both write, ex_rs1=7 → fwd_a_sel=01; mem_reg_write=0 → 10; ex_rs2=0 with mem_rd=0 writing → fwd_b_sel=00.
- Memory wait: mem_access=1, mem_ready=0 for 3 cycles, then 1 → enables=0 for 3 cycles, state MEM_WAIT, 4th cycle normal advance, back to RUN; stall_cycles=3.
- Timeout (MEM_TIMEOUT=4): mem_ready held 0 → 5 stall cycles, then HALT with halted=1, enables stay 0; rst pulse → RUN, halted=0, stall_cycles=0.
- Reset mid-MEM_WAIT → next cycle RUN, wait_cnt=0; flushes asserted while rst=1.
